// File: rtl/writeback_arbiter.sv
// Merges ALU results (1-entry buffer) and load data (2-entry FIFO) onto one
// register-file write port, with starvation relief for the ALU and load scoreboarding.
module writeback_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_valid,
  input  logic [ADDR_WIDTH-1:0]      alu_rd,
  input  logic [DATA_WIDTH-1:0]      alu_data,
  output logic                       alu_ready,
  input  logic                       mem_valid,
  input  logic [ADDR_WIDTH-1:0]      mem_rd,
  input  logic [DATA_WIDTH-1:0]      mem_data,
  output logic                       mem_ready,
  input  logic                       issue_valid,
  input  logic [ADDR_WIDTH-1:0]      issue_rd,
  output logic                       wb_en,
  output logic [ADDR_WIDTH-1:0]      wb_addr,
  output logic [DATA_WIDTH-1:0]      wb_data,
  output logic [(1<<ADDR_WIDTH)-1:0] busy_mask
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam int SW   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic                  alu_v_reg;
  logic [ADDR_WIDTH-1:0] alu_rd_reg;
  logic [DATA_WIDTH-1:0] alu_data_reg;

  logic [ADDR_WIDTH-1:0] mem_rd_reg   [2];
  logic [DATA_WIDTH-1:0] mem_data_reg [2];
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [1:0]            mem_cnt_reg;

  logic [SW-1:0]         starve_reg;
  logic [NREG-1:0]       busy_reg;
  logic [NREG-1:0]       busy_next;

  logic                  mem_v;
  logic                  alu_sel;
  logic                  mem_sel;
  logic                  alu_take;
  logic                  mem_take;
  logic [ADDR_WIDTH-1:0] mem_head_rd;

  assign mem_v       = (mem_cnt_reg != 2'd0);
  assign mem_head_rd = mem_rd_reg[rd_ptr_reg];
  // Loads win ties unless the ALU has already lost STARVE_LIMIT times in a row
  assign alu_sel     = alu_v_reg && (!mem_v || (starve_reg == SW'(STARVE_LIMIT)));
  assign mem_sel     = mem_v && !alu_sel;

  assign alu_ready   = !alu_v_reg || alu_sel;
  assign mem_ready   = (mem_cnt_reg < 2'd2);
  assign alu_take    = alu_valid && alu_ready && (alu_rd != '0);
  assign mem_take    = mem_valid && mem_ready && (mem_rd != '0);

  always_comb begin
    wb_en   = alu_v_reg || mem_v;
    wb_addr = '0;
    wb_data = '0;
    if (alu_sel) begin
      wb_addr = alu_rd_reg;
      wb_data = alu_data_reg;
    end else if (mem_sel) begin
      wb_addr = mem_head_rd;
      wb_data = mem_data_reg[rd_ptr_reg];
    end
  end

  // A set from a new issue overrides a clear from a writeback of the same register
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_bit
        assign busy_next[gi] = (issue_valid && (issue_rd == ADDR_WIDTH'(gi))) ||
                               (busy_reg[gi] && !(mem_sel && (mem_head_rd == ADDR_WIDTH'(gi))));
      end
    end
  endgenerate

  assign busy_mask = busy_reg;

  always_ff @(posedge clk) begin
    if (mem_take) begin
      mem_rd_reg[wr_ptr_reg]   <= mem_rd;
      mem_data_reg[wr_ptr_reg] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_v_reg    <= 1'b0;
      alu_rd_reg   <= '0;
      alu_data_reg <= '0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      mem_cnt_reg  <= 2'd0;
      starve_reg   <= '0;
      busy_reg     <= '0;
    end else begin
      if (alu_take) begin
        alu_v_reg    <= 1'b1;
        alu_rd_reg   <= alu_rd;
        alu_data_reg <= alu_data;
      end else if (alu_sel) begin
        alu_v_reg <= 1'b0;
      end

      if (mem_take) wr_ptr_reg <= ~wr_ptr_reg;
      if (mem_sel)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({mem_take, mem_sel})
        2'b10:   mem_cnt_reg <= mem_cnt_reg + 2'd1;
        2'b01:   mem_cnt_reg <= mem_cnt_reg - 2'd1;
        default: mem_cnt_reg <= mem_cnt_reg;
      endcase

      if (alu_sel)
        starve_reg <= '0;
      else if (alu_v_reg && mem_sel && (starve_reg != SW'(STARVE_LIMIT)))
        starve_reg <= starve_reg + SW'(1);

      busy_reg <= busy_next;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed and randomized checks of writeback_arbiter against a queue-based reference model.
module tb_writeback_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int LIMIT = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_rd = '0;
  logic [DW-1:0] alu_data = '0;
  logic          alu_ready;
  logic          mem_valid = 1'b0;
  logic [AW-1:0] mem_rd = '0;
  logic [DW-1:0] mem_data = '0;
  logic          mem_ready;
  logic          issue_valid = 1'b0;
  logic [AW-1:0] issue_rd = '0;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [31:0]   busy_mask;

  int tests = 0;
  int fails = 0;

  writeback_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending results as queues, scoreboard as a bit vector
  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t        aq[$];
  ent_t        mq[$];
  int          starve = 0;
  logic [31:0] busy = '0;
  bit          m_aw, m_ardy, m_mrdy, m_mv, m_av;

  function automatic bit model_alu_wins();
    return (aq.size() != 0) && ((mq.size() == 0) || (starve == LIMIT));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aq.delete();
      mq.delete();
      starve = 0;
      busy   = '0;
    end else begin
      m_av   = (aq.size() != 0);
      m_mv   = (mq.size() != 0);
      m_aw   = model_alu_wins();
      m_ardy = !m_av || m_aw;
      m_mrdy = (mq.size() < 2);
      if (m_aw) begin
        void'(aq.pop_front());
        starve = 0;
      end else if (m_mv) begin
        busy[mq[0].rd] = 1'b0;
        void'(mq.pop_front());
        if (m_av) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
      end
      if (alu_valid && m_ardy && alu_rd != 0) aq.push_back('{rd: alu_rd, data: alu_data});
      if (mem_valid && m_mrdy && mem_rd != 0) mq.push_back('{rd: mem_rd, data: mem_data});
      if (issue_valid && issue_rd != 0) busy[issue_rd] = 1'b1;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic          e_en;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    bit            aw;
    aw     = model_alu_wins();
    e_en   = (aq.size() != 0) || (mq.size() != 0);
    e_addr = '0;
    e_data = '0;
    if (aw) begin
      e_addr = aq[0].rd;
      e_data = aq[0].data;
    end else if (mq.size() != 0) begin
      e_addr = mq[0].rd;
      e_data = mq[0].data;
    end
    check("wb_en", 64'(wb_en), 64'(e_en));
    check("wb_addr", 64'(wb_addr), 64'(e_addr));
    check("wb_data", 64'(wb_data), 64'(e_data));
    check("alu_ready", 64'(alu_ready), 64'((aq.size() == 0) || aw));
    check("mem_ready", 64'(mem_ready), 64'(mq.size() < 2));
    check("busy_mask", 64'(busy_mask), 64'(busy));
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid   = 1'b0;
    mem_valid   = 1'b0;
    issue_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wb_en", 64'(wb_en), 64'd0);
    check("rst_alu_ready", 64'(alu_ready), 64'd1);
    check("rst_mem_ready", 64'(mem_ready), 64'd1);
    check("rst_busy", 64'(busy_mask), 64'd0);
    next_cycle();
    rst_n = 1'b1;

    // Single ALU result: written the cycle after acceptance, for one cycle
    next_cycle();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    next_cycle();
    alu_valid = 1'b0;
    @(negedge clk);
    check("alu_wb_en", 64'(wb_en), 64'd1);
    check("alu_wb_addr", 64'(wb_addr), 64'd5);
    check("alu_wb_data", 64'(wb_data), 64'h1234);
    @(negedge clk);
    check("alu_wb_once", 64'(wb_en), 64'd0);

    // Load scoreboard: busy from issue until load writeback
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd7;
    next_cycle();
    issue_valid = 1'b0;
    @(negedge clk);
    check("busy7_set", 64'(busy_mask[7]), 64'd1);
    next_cycle();
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'hDEADBEEF;
    next_cycle();
    mem_valid = 1'b0;
    @(negedge clk);
    check("ld_wb_addr", 64'(wb_addr), 64'd7);
    check("ld_wb_data", 64'(wb_data), 64'hDEADBEEF);
    check("busy7_held", 64'(busy_mask[7]), 64'd1);
    @(negedge clk);
    check("busy7_clr", 64'(busy_mask[7]), 64'd0);

    // Starvation: mem wins three times, then the ALU; FIFO then fills
    next_cycle();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'hB;
    next_cycle();
    alu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("starve_addr", 64'(wb_addr), (i < 3) ? 64'd9 : 64'd3);
      if (i == 0) check("starve_alu_rdy", 64'(alu_ready), 64'd0);
    end
    @(negedge clk);
    check("fifo_full", 64'(mem_ready), 64'd0);
    next_cycle();
    idle_inputs();
    repeat (4) next_cycle();

    // rd = 0 transfers are accepted and discarded
    alu_valid = 1'b1; alu_rd = '0; alu_data = 32'h55;
    mem_valid = 1'b1; mem_rd = '0; mem_data = 32'h66;
    @(negedge clk);
    check("rd0_alu_rdy", 64'(alu_ready), 64'd1);
    check("rd0_mem_rdy", 64'(mem_ready), 64'd1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("rd0_no_wb", 64'(wb_en), 64'd0);
    check("rd0_busy", 64'(busy_mask), 64'd0);

    // Randomized traffic with occasional mid-operation resets
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      rst_n       = ($urandom_range(0, 299) != 0);
      alu_valid   = ($urandom_range(0, 2) != 0);
      alu_rd      = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
      alu_data    = $urandom;
      mem_valid   = ($urandom_range(0, 3) != 0);
      mem_rd      = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
      mem_data    = $urandom;
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = AW'($urandom_range(0, 31));
    end
    next_cycle();
    rst_n = 1'b1;
    idle_inputs();
    repeat (4) next_cycle();

    // Reset with both paths holding results and a busy bit set
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
    mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h66;
    issue_valid = 1'b1; issue_rd = 5'd6;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("pre_rst_wb_en", 64'(wb_en), 64'd1);
    check("pre_rst_busy6", 64'(busy_mask[6]), 64'd1);
    next_cycle();
    rst_n = 1'b0;
    #1;
    check("async_rst_wb_en", 64'(wb_en), 64'd0);
    check("async_rst_addr", 64'(wb_addr), 64'd0);
    check("async_rst_data", 64'(wb_data), 64'd0);
    check("async_rst_busy", 64'(busy_mask), 64'd0);
    check("async_rst_ardy", 64'(alu_ready), 64'd1);
    check("async_rst_mrdy", 64'(mem_ready), 64'd1);
    repeat (2) next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_wb", 64'(wb_en), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of the result data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, the width of the destination register index.
REQ-003 SHALL have parameter STARVE_LIMIT, default 3, the number of consecutive lost arbitrations after which the ALU wins.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports are as listed in REQ-005 to REQ-020.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 alu_valid  input  1  an ALU result is offered.
REQ-008 alu_rd  input  ADDR_WIDTH  the ALU result's destination register.
REQ-009 alu_data  input  DATA_WIDTH  the ALU result value.
REQ-010 alu_ready  output  1  the ALU result is accepted this cycle.
REQ-011 mem_valid  input  1  load data is offered.
REQ-012 mem_rd  input  ADDR_WIDTH  the load's destination register.
REQ-013 mem_data  input  DATA_WIDTH  the load data value.
REQ-014 mem_ready  output  1  the load data is accepted this cycle.
REQ-015 issue_valid  input  1  a load is being issued this cycle.
REQ-016 issue_rd  input  ADDR_WIDTH  the destination register of the issued load.
REQ-017 wb_en  output  1  write enable to the register file write port.
REQ-018 wb_addr  output  ADDR_WIDTH  write address to the register file.
REQ-019 wb_data  output  DATA_WIDTH  write data to the register file.
REQ-020 busy_mask  output  2^ADDR_WIDTH  one bit per register with an outstanding load; bit 0 always 0.

Function
REQ-021 An input transfer SHALL occur on a rising edge when valid and ready are both high; data SHALL be sampled only then.
REQ-022 The ALU path SHALL hold a 1-entry buffer; alu_ready SHALL be high when that buffer is empty or is being written back this cycle.
REQ-023 The mem path SHALL hold a 2-entry FIFO; mem_ready SHALL equal (count < 2), with no pop-through; a push and a pop in the same cycle SHALL leave the count unchanged.
REQ-024 A transfer whose rd is 0 SHALL be accepted and discarded; it never enters a buffer and never asserts wb_en.
REQ-025 wb_en/wb_addr/wb_data SHALL be driven combinationally from the selected buffer head; the entry pops on the edge where wb_en is high, so a result accepted at edge N is written to the register file at the earliest at edge N+1.
REQ-026 Arbitration: ALU-only entry valid -> ALU is selected; mem-only entry valid -> mem is selected; both valid -> mem is selected unless starve_cnt == STARVE_LIMIT, in which case ALU is selected.
REQ-027 starve_cnt: increments, saturating at STARVE_LIMIT, each cycle the ALU entry is valid and loses; clears when the ALU entry is written; holds otherwise.
REQ-028 With no entries valid, wb_en SHALL be 0 and wb_addr/wb_data SHALL be 0.
REQ-029 busy_mask[issue_rd] SHALL set on an edge with issue_valid high and issue_rd != 0; issue_rd == 0 SHALL be ignored.
REQ-030 busy_mask[wb_addr] SHALL clear on the edge where a mem entry is written back.
REQ-031 A simultaneous set and clear of the same bit SHALL leave the bit set.
REQ-032 No ordering SHALL be guaranteed between ALU and mem results to the same rd; upstream uses busy_mask to avoid this case.

Reset
REQ-033 On rst_n low, asynchronously: both buffers empty, FIFO count 0, starve_cnt 0, busy_mask 0, wb_en 0, wb_addr 0, wb_data 0, alu_ready 1, mem_ready 1.
REQ-034 Reset mid-operation SHALL drop all buffered results without writing them; no wb_en pulse SHALL occur while rst_n is low.

Verification
REQ-035 ALU rd=5 data=0x1234 alone at edge N -> wb_en=1, wb_addr=5, wb_data=0x1234 in the cycle after N for exactly 1 cycle.
REQ-036 Load issue rd=7, then mem rd=7 data=0xDEADBEEF -> busy_mask[7]=1 from the issue edge until the writeback edge, then 0.
REQ-037 Three mem results back-to-back with no pops -> mem_ready=0 after 2 accepts; the third is held and accepted after the first pop; all three are written in order.
REQ-038 ALU entry pending with continuous mem traffic (default STARVE_LIMIT) -> mem wins 3 cycles, ALU written on the 4th, starve_cnt returns to 0.
REQ-039 ALU rd=0 and mem rd=0 transfers -> both accepted, wb_en stays 0, busy_mask unchanged.
REQ-040 Assert rst_n low with both buffers full and busy bits set -> all outputs match REQ-033 immediately; no write of the dropped data after release.
